// File: rtl/add_nlayers.sv
// N-channel pixel-plane adder: planes stream in one after another, are summed in a
// frame buffer, and the combined pixel is emitted while the last plane arrives.
module add_nlayers #(
    parameter int D          = 299,
    parameter int data_width = 32,
    parameter int N          = 4,
    parameter int SHIFT      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             valid_in,
    input  logic [N*data_width-1:0]  pxl_in,
    input  logic [1:0]               mode,
    output logic [data_width-1:0]    pxl_out,
    output logic                     valid_out,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     drop_err
);
    localparam int P     = D * D;
    localparam int AW    = (P > 1) ? $clog2(P) : 1;
    localparam int CW    = $clog2(N);
    localparam int ACC_W = data_width + $clog2(N);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LAST} state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_ch;
    logic [AW-1:0]            r_addr;
    logic [1:0]               r_mode;
    logic signed [ACC_W-1:0]  r_buf [P];

    logic [data_width-1:0]    w_lane [N];
    logic [N-1:0]             w_sel;
    logic                     w_accept;
    logic                     w_drop;
    logic [data_width-1:0]    w_pix;
    logic signed [ACC_W-1:0]  w_pix_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_mean;
    logic [data_width-1:0]    w_fmt;
    logic                     w_addr_last;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign w_lane[gi] = pxl_in[gi*data_width +: data_width];
        end
    endgenerate

    // Only the lane matching the expected channel is consumed; any other strobe is an error.
    assign w_sel       = N'(1) << r_ch;
    assign w_accept    = |(valid_in & w_sel);
    assign w_drop      = |(valid_in & ~w_sel);
    assign w_pix       = w_lane[r_ch];
    assign w_pix_ext   = {{(ACC_W-data_width){w_pix[data_width-1]}}, w_pix};
    assign w_sum       = r_buf[r_addr] + w_pix_ext;
    assign w_mean      = w_sum >>> SHIFT;
    assign w_addr_last = (r_addr == AW'(P-1));

    function automatic logic [data_width-1:0] clamp(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(data_width-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(data_width-1){1'b0}}};
        else
            return v[data_width-1:0];
    endfunction

    always_comb begin
        w_fmt = clamp(w_sum);
        case (r_mode)
            2'd0:    w_fmt = w_sum[data_width-1:0];
            2'd2:    w_fmt = clamp(w_mean);
            default: w_fmt = clamp(w_sum);
        endcase
    end

    // Channel 0 overwrites, so stale contents from an aborted frame never leak through.
    always_ff @(posedge clk) begin
        if (w_accept && r_state != S_LAST)
            r_buf[r_addr] <= (r_ch == '0) ? w_pix_ext : w_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_addr     <= '0;
            r_mode     <= '0;
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (w_drop)
                drop_err <= 1'b1;
            if (w_accept) begin
                if (r_state == S_IDLE) begin
                    r_mode <= mode;
                    busy   <= 1'b1;
                end
                if (r_state == S_LAST) begin
                    valid_out <= 1'b1;
                    pxl_out   <= w_fmt;
                end
                if (w_addr_last) begin
                    r_addr <= '0;
                    if (r_state == S_LAST) begin
                        r_ch       <= '0;
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= (r_ch == CW'(N-2)) ? S_LAST : S_ACCUM;
                    end
                end else begin
                    r_addr <= r_addr + 1'b1;
                    if (r_state == S_IDLE)
                        r_state <= S_ACCUM;
                end
            end
        end
    end
endmodule

// File: tb/tb_add_nlayers.sv
// Self-checking bench for add_nlayers: directed planes plus random frames, compared
// against a per-pixel sum-and-format model with a latency-stamped scoreboard.
module tb_add_nlayers;
    localparam int D = 2, N = 3, W = 8, SHIFT = 2, P = D * D;
    localparam int MAXV = (1 << (W-1)) - 1;
    localparam int MINV = -(1 << (W-1));

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   valid_in;
    logic [N*W-1:0] pxl_in;
    logic [1:0]     mode;
    logic [W-1:0]   pxl_out;
    logic           valid_out, frame_done, busy, drop_err;

    add_nlayers #(.D(D), .data_width(W), .N(N), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .mode(mode),
        .pxl_out(pxl_out), .valid_out(valid_out), .frame_done(frame_done),
        .busy(busy), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int pl [N][P];
    int exp_val[$], exp_cyc[$];
    bit exp_fd[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int sat(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic int fmt(input int s, input int m);
        int r;
        case (m)
            0: begin
                r = s & ((1 << W) - 1);
                if (r > MAXV) r -= (1 << W);
            end
            2:       r = sat(s >>> SHIFT);
            default: r = sat(s);
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        int v, c;
        bit fd;
        if (!reset) begin
            if (valid_out) begin
                if (exp_val.size() == 0) chk("spurious_valid_out", 1, 0);
                else begin
                    v = exp_val.pop_front(); c = exp_cyc.pop_front(); fd = exp_fd.pop_front();
                    chk("pxl_out", $signed(pxl_out), v);
                    chk("latency", cyc, c);
                    chk("frame_done", frame_done, fd);
                    chk("busy", busy, !fd);
                end
            end else if (frame_done) chk("stray_frame_done", 1, 0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input int c, input int p, input int m, input logic [N-1:0] extra);
        int s;
        pxl_in = (N*W)'($urandom);
        pxl_in[c*W +: W] = W'(pl[c][p]);
        valid_in = extra;
        valid_in[c] = 1'b1;
        if (c == N-1) begin
            s = 0;
            for (int k = 0; k < N; k++) s += pl[k][p];
            exp_val.push_back(fmt(s, m));
            exp_cyc.push_back(cyc + 1);
            exp_fd.push_back(p == P-1);
        end
        tick();
        valid_in = '0;
    endtask

    task automatic run_frame(input int m, input int gap, input bit drop);
        mode = 2'(m);
        for (int c = 0; c < N; c++)
            for (int p = 0; p < P; p++) begin
                if (drop && c == 0 && p == 1) begin
                    valid_in = 3'b010;
                    pxl_in = (N*W)'($urandom);
                    tick();
                    valid_in = '0;
                end
                drive(c, p, m, (drop && c == 0 && p == 2) ? 3'b100 : 3'b000);
                if (c == 0 && p == 0) mode = 2'($urandom);
                for (int g = 0; g < gap; g++) tick();
            end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_val.size() != 0 && k < 5) begin
            @(negedge clk);
            k++;
        end
        if (exp_val.size() != 0) begin
            chk("drain_timeout", exp_val.size(), 0);
            exp_val.delete(); exp_cyc.delete(); exp_fd.delete();
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < N; c++)
            for (int p = 0; p < P; p++) pl[c][p] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; valid_in = '0; pxl_in = '0; mode = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pxl_out", pxl_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_err", drop_err, 0);
        reset = 1'b0;
        tick();

        pl[0] = '{1, 2, 3, 4}; pl[1] = '{10, 20, 30, 40}; pl[2] = '{50, 60, 70, 80};
        run_frame(0, 0, 0); drain();

        pl[0] = '{100, -100, 127, -128}; pl[1] = '{100, -100, 127, -128}; pl[2] = '{100, -100, 1, -1};
        run_frame(1, 0, 0); drain();
        run_frame(3, 0, 0); drain();
        run_frame(0, 0, 0); drain();

        pl[0] = '{8, -5, 0, -1}; pl[1] = '{8, -5, 0, -1}; pl[2] = '{9, -5, 3, 0};
        run_frame(2, 0, 0); drain();
        chk("no_drop_yet", drop_err, 0);

        fill_random();
        run_frame(1, 0, 1); drain();
        chk("drop_err_set", drop_err, 1);
        tick();
        chk("drop_err_sticky", drop_err, 1);

        fill_random();
        run_frame(0, 3, 0); drain();

        fill_random();
        mode = 2'd1;
        for (int p = 0; p < P; p++) drive(0, p, 1, 3'b000);
        drive(1, 0, 1, 3'b000);
        drive(1, 1, 1, 3'b000);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_drop_err", drop_err, 0);
        chk("async_rst_pxl_out", pxl_out, 0);
        chk("async_rst_valid_out", valid_out, 0);
        tick();
        reset = 1'b0;

        fill_random();
        run_frame(0, 0, 0); drain();
        chk("post_rst_drop_err", drop_err, 0);

        for (int i = 0; i < 8; i++) begin
            fill_random();
            run_frame($urandom_range(0, 3), $urandom_range(0, 2), 0);
            drain();
        end

        repeat (3) tick();
        chk("final_busy", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/add_nlayers.md
# add_nlayers

Parametrised N-channel pixel-plane adder: generalised successor of the three-layer adder. Accepts N image planes of D×D signed pixels, streamed one plane after another on per-channel valid/data lanes. Accumulates them in an internal frame buffer and emits the per-pixel combined result while the last plane streams in. Output is wrap-around, saturating, or shifted-mean, selectable per frame. Sits between the per-channel pixel sources and downstream conv/pool stages.

## Interface
- `D`, 299: image side; frame = D*D pixels.
- `data_width`, 32: pixel width, two's complement.
- `N`, 4: channel count, 2..16.
- `SHIFT`, 2: arithmetic right shift applied in mean mode.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `valid_in`  in  N: per-channel pixel strobe; bit c qualifies lane c.
- `pxl_in`  in  N*data_width: lane c = bits [c*data_width +: data_width].
- `mode`  in  2: 0 wrap, 1 saturate, 2 mean (>>>SHIFT then saturate), 3 treated as 1.
- `pxl_out`  out  data_width: combined pixel.
- `valid_out`  out  1: pxl_out qualifier.
- `frame_done`  out  1: one-cycle pulse with the last valid_out of a frame.
- `busy`  out  1: high from first accepted pixel of channel 0 until frame_done.
- `drop_err`  out  1: sticky; set when a valid arrives on a non-expected lane.

## Operation
- Internal frame buffer: D*D words of ACC_W = data_width + clog2(N) bits, signed.
- Counters: `ch` (0..N-1) is the expected channel; `addr` (0..D*D-1) is the pixel index.
- States: IDLE (ch=0, addr=0, busy=0), ACCUM (channels 0..N-2), LAST (channel N-1).
- Only `valid_in[ch]` is accepted. Each accepted pixel advances `addr`. At `addr` = D*D-1, `addr` wraps to 0 and `ch` increments.
- ch=0: buffer[addr] ← sign-extended pixel. This overwrites, so no clear pass is needed.
- 0<ch<N-1: buffer[addr] ← buffer[addr] + sign-extended pixel.
- ch=N-1: sum = buffer[addr] + pixel is formatted and emitted; the buffer is not written.
- Output formatting:
  - wrap: low data_width bits of sum.
  - saturate: clamp to [−2^(w−1), 2^(w−1)−1].
  - mean: sum >>> SHIFT, then clamp.
- `mode` is sampled into a register on the first accepted channel-0 pixel and held for the whole frame.
- After the last pixel of ch=N-1 the block returns to IDLE; the next frame may start on the following cycle.
- Any asserted `valid_in[k]` with k≠ch sets `drop_err`. The pixel is ignored and the counters do not move. `drop_err` is cleared only by reset.
- If several lanes are asserted together, only the lane equal to `ch` is used; the others set `drop_err`.
- Gaps (no valid) stall the counters; there is no timeout.

## Timing
- Throughput: one pixel per cycle per active plane, no backpressure.
- Latency: `valid_out`/`pxl_out` register one cycle after the accepting edge of a ch=N-1 pixel.
- `frame_done` is asserted in the same cycle as the valid_out for addr=D*D-1 of ch=N-1.
- `busy` rises the cycle after the first channel-0 acceptance and falls in the frame_done cycle.
- Buffer read is combinational on `addr`; the write happens on the accepting edge. No read-after-write hazard, because each address is touched at most once per plane.
- Reset values: pxl_out=0, valid_out=0, frame_done=0, busy=0, drop_err=0, ch=0, addr=0, mode register=0. Buffer contents are don't-care.
- Reset asserted mid-frame: all outputs drop immediately (asynchronous), the partial frame is discarded, and the next accepted pixel is treated as channel 0, addr 0.

## Test plan
- D=2, N=3, wrap. Lane0 plane {1,2,3,4}, lane1 {10,20,30,40}, lane2 {100,200,300,400}, fed back-to-back -> pxl_out 111,222,333,444 on 4 consecutive cycles, each one cycle after its lane2 pixel. frame_done with 444; busy spans the frame.
- Saturate, data_width=8, N=3. Pixels 100+100+100 and −100−100−100 -> 127 and −128. Same stimulus in wrap mode -> 44 and −44.
- Mean mode, SHIFT=2, N=4. Planes of 8,8,8,9 -> 8. Planes of −5,−5,−5,−5 -> −5.
- Lane1 pulse while ch=0 -> drop_err=1 (sticky), counters unchanged. Frame still completes with correct sums.
- Idle gaps of 3 cycles between pixels -> results identical to the back-to-back case; valid_out only after lane N-1 pixels.
- Reset asserted after 2 pixels of ch=1 -> all outputs 0 at once. A fresh full frame then gives correct sums with no residue from the aborted frame. Two frames back-to-back give independent results.
